hilo_mult_unit: RTL and testbench
=================================

// Module: hilo_mult_unit
// PURPOSE
//  Multi-cycle multiply/accumulate unit that owns the HI/LO register pair. It
//  is the responder for the HI/LO operations the single-cycle ALU does not execute.
//  Performs MULT, MULTU, MADD, MSUB, MTHI and MTLO. The datapath issues one
//  request with Start and holds the pipeline while Busy=1.
//  HI/LO feed the MFHI/MFLO writeback mux directly.
// PARAMETERS
//  DATA_WIDTH  32  operand width; HI and LO are each DATA_WIDTH bits; iterations = DATA_WIDTH
// PORTS
//  Clk    in   1   clock, all state updates on the rising edge
//  Rst    in   1   synchronous reset, active low
//  Start  in   1   request strobe; sampled only when Busy=0
//  Op     in   3   000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 11x no-op
//  A      in   32  rs operand (multiplicand, or MTHI/MTLO source)
//  B      in   32  rt operand (multiplier)
//  Busy   out  1   high while a multiply is in flight; the datapath stalls
//  Done   out  1   one-cycle pulse when HI/LO have been updated
//  HI     out  32  HI register
//  LO     out  32  LO register
// BEHAVIOUR
//  - Reset (Rst=0 at an edge): HI=0, LO=0, Busy=0, Done=0, state=IDLE. Any
//    in-flight operation is aborted and no partial result is written.
//  - States: IDLE, CALC, FINISH.
//    - IDLE -> CALC on Start with Op in 000..011.
//    - CALC -> FINISH after DATA_WIDTH iterations.
//    - FINISH -> IDLE.
//  - MTHI/MTLO: executed in IDLE with no state change. At edge N, HI<=A (or
//    LO<=A) and Done=1 during cycle N+1. Busy stays 0.
//  - Multiply request accepted at edge N:
//    - Latches |A| and |B| (signed ops) or A and B (MULTU), the result sign,
//      and the Op.
//    - Clears the 64-bit product and the iteration counter. Busy=1 from N+1.
//  - CALC, edges N+1..N+32: radix-2 shift-add, one multiplier bit per edge.
//    The counter counts 0..31; the exit is taken when the counter reaches 31.
//  - FINISH, edge N+33:
//    - P = product, negated (two's complement, 64-bit) if the result sign is 1.
//    - MULT/MULTU write {HI,LO}<=P.
//    - MADD writes {HI,LO}<={HI,LO}+P. MSUB writes {HI,LO}<={HI,LO}-P.
//    - 64-bit modulo arithmetic; overflow wraps silently.
//    - Busy=0 and Done=1 during cycle N+34.
//    - Total multiply latency is 34 cycles from the Start edge to valid HI/LO.
//  - MADD and MSUB are signed. MULTU treats both operands as unsigned.
//  - Signed magnitude of 0x80000000 is 0x80000000 taken as unsigned. The
//    product must stay correct for this case.
//  - Start while Busy=1 is ignored. Operands are never re-latched mid-operation.
//  - Start in IDLE with Op=11x: ignored, no Done pulse.
//  - HI/LO hold their values during CALC. They change only in FINISH or on MTHI/MTLO.
//  - Done is high for exactly one cycle per completed operation. A new Start
//    may be accepted in the same cycle that Done is high.
// TESTING
//  1. Op=MULT, A=0xFFFFFFFD (-3), B=5 -> Busy high for 33 cycles; then HI=FFFFFFFF, LO=FFFFFFF1, Done pulses once.
//  2. Op=MULTU, A=B=0xFFFFFFFF -> HI=FFFFFFFE, LO=00000001 after 34 cycles.
//  3. MTLO A=10, then MADD A=2,B=3 -> HI=0, LO=16. Then MSUB A=2,B=9 -> HI=FFFFFFFF, LO=FFFFFFFE.
//  4. MULT A=0x80000000, B=0x80000000 -> HI=40000000, LO=00000000.
//  5. During MULT A=7,B=6, pulse Start with MTHI A=0xDEAD at cycle 10 -> ignored; final HI=0, LO=42.
//  6. Start MULT A=7,B=6, then drive Rst=0 at cycle 15 -> next edge HI=LO=0, Busy=0, no Done ever pulses.

Source files
------------

// File: rtl/hilo_mult_unit_if.sv
// ============================================================================
// Module      : hilo_mult_unit_if
// Description : Request/response bundle between the datapath and the HI/LO
//               multiply/accumulate unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_mult_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [2:0]            Op;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] HI;
    logic [DATA_WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/hilo_mult_unit.sv
// ============================================================================
// Module      : hilo_mult_unit
// Description : Multi-cycle radix-2 shift-add multiply/accumulate unit that
//               owns the HI/LO pair (MULT, MULTU, MADD, MSUB, MTHI, MTLO).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mult_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic         Clk,
    input  wire logic         Rst,
    hilo_mult_unit_if.slave   bus
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_madd  = 3'b010;
    localparam logic [2:0] c_op_msub  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;

    localparam logic [CW-1:0] c_last_iter = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [PW-1:0]         mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic                  neg_q,    neg_d;
    logic [1:0]            op_q,     op_d;
    logic [PW-1:0]         prod_q,   prod_d;
    logic [DATA_WIDTH-1:0] hi_q,     hi_d;
    logic [DATA_WIDTH-1:0] lo_q,     lo_d;
    logic                  done_q,   done_d;

    logic                  w_signed_req;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [PW-1:0]         w_prod_signed;
    logic [PW-1:0]         w_result;

    // Magnitudes are taken as unsigned, so -0x80000000 stays 0x80000000 and
    // the unsigned shift-add below still yields the right product.
    assign w_signed_req  = (bus.Op != c_op_multu);
    assign w_a_mag       = (w_signed_req && bus.A[DATA_WIDTH-1]) ? -bus.A : bus.A;
    assign w_b_mag       = (w_signed_req && bus.B[DATA_WIDTH-1]) ? -bus.B : bus.B;
    assign w_prod_signed = neg_q ? -prod_q : prod_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        w_result = w_prod_signed;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        c_op_mult, c_op_multu, c_op_madd, c_op_msub: begin
                            mcand_d  = {{DATA_WIDTH{1'b0}}, w_a_mag};
                            mplier_d = w_b_mag;
                            neg_d    = w_signed_req && (bus.A[DATA_WIDTH-1] ^ bus.B[DATA_WIDTH-1]);
                            op_d     = bus.Op[1:0];
                            prod_d   = '0;
                            cnt_d    = '0;
                            state_d  = ST_CALC;
                        end
                        c_op_mthi: begin
                            hi_d   = bus.A;
                            done_d = 1'b1;
                        end
                        c_op_mtlo: begin
                            lo_d   = bus.A;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_CALC: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_last_iter) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                case ({1'b0, op_q})
                    c_op_madd: w_result = {hi_q, lo_q} + w_prod_signed;
                    c_op_msub: w_result = {hi_q, lo_q} - w_prod_signed;
                    default:   w_result = w_prod_signed;
                endcase
                {hi_d, lo_d} = w_result;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Reset abandons any multiply in flight; HI/LO are cleared, never partially written.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.Busy = (state_q != ST_IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
// ============================================================================
// Module      : tb_hilo_mult_unit
// Description : Directed self-checking bench for hilo_mult_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_mult_unit;

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_madd  = 3'b010;
    localparam logic [2:0] c_op_msub  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    hilo_mult_unit_if #(.DATA_WIDTH(32)) bif ();

    hilo_mult_unit #(.DATA_WIDTH(32)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request for a single cycle; returns at the negedge of cycle N+1.
    task automatic pulse_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bif.Start = 1'b1;
        bif.Op    = op;
        bif.A     = a;
        bif.B     = b;
        @(negedge clk);
        bif.Start = 1'b0;
    endtask

    task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int busy_cnt, output int done_cnt, output int done_idx);
        pulse_start(op, a, b);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        for (int i = 1; i <= 60; i++) begin
            if (bif.Busy) busy_cnt++;
            if (bif.Done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bif.Done && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, done_idx, cyc;
        tests_run    = 0;
        tests_failed = 0;
        bif.Start    = 1'b0;
        bif.Op       = 3'b000;
        bif.A        = '0;
        bif.B        = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_hi",   64'(bif.HI),   64'h0);
        check_val("reset_lo",   64'(bif.LO),   64'h0);
        check_val("reset_busy", 64'(bif.Busy), 64'h0);
        check_val("reset_done", 64'(bif.Done), 64'h0);
        rst_n = 1'b1;

        // -3 * 5
        run_mul(c_op_mult, 32'hFFFF_FFFD, 32'd5, busy_cnt, done_cnt, done_idx);
        check_val("mult_busy_cycles", 64'(busy_cnt), 64'd33);
        check_val("mult_done_count",  64'(done_cnt), 64'd1);
        check_val("mult_done_cycle",  64'(done_idx), 64'd34);
        check_val("mult_hilo", {bif.HI, bif.LO}, 64'hFFFF_FFFF_FFFF_FFF1);

        run_mul(c_op_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_cnt, done_cnt, done_idx);
        check_val("multu_hilo",       {bif.HI, bif.LO}, 64'hFFFF_FFFE_0000_0001);
        check_val("multu_done_cycle", 64'(done_idx), 64'd34);

        run_mul(c_op_multu, 32'h8000_0000, 32'd2, busy_cnt, done_cnt, done_idx);
        check_val("multu_msb_hilo", {bif.HI, bif.LO}, 64'h0000_0001_0000_0000);

        // MTHI / MTLO: immediate, one-cycle Done, no Busy
        pulse_start(c_op_mthi, 32'h0, 32'h0);
        check_val("mthi_done", 64'(bif.Done), 64'h1);
        check_val("mthi_hi",   64'(bif.HI),   64'h0);
        pulse_start(c_op_mtlo, 32'd10, 32'h0);
        check_val("mtlo_done", 64'(bif.Done), 64'h1);
        check_val("mtlo_busy", 64'(bif.Busy), 64'h0);
        check_val("mtlo_lo",   64'(bif.LO),   64'd10);
        @(negedge clk);
        check_val("mtlo_done_drop", 64'(bif.Done), 64'h0);

        run_mul(c_op_madd, 32'd2, 32'd3, busy_cnt, done_cnt, done_idx);
        check_val("madd_hilo", {bif.HI, bif.LO}, 64'd16);
        check_val("madd_done_count", 64'(done_cnt), 64'd1);
        run_mul(c_op_msub, 32'd2, 32'd9, busy_cnt, done_cnt, done_idx);
        check_val("msub_hilo", {bif.HI, bif.LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        run_mul(c_op_mult, 32'h8000_0000, 32'h8000_0000, busy_cnt, done_cnt, done_idx);
        check_val("mult_minint_hilo", {bif.HI, bif.LO}, 64'h4000_0000_0000_0000);

        // Reserved op: no Done, no Busy, HI/LO untouched
        pulse_start(3'b110, 32'h55, 32'h66);
        check_val("noop_done", 64'(bif.Done), 64'h0);
        check_val("noop_busy", 64'(bif.Busy), 64'h0);
        check_val("noop_hilo", {bif.HI, bif.LO}, 64'h4000_0000_0000_0000);

        // MTHI issued mid-multiply must be ignored; HI holds during CALC
        pulse_start(c_op_mult, 32'd7, 32'd6);
        done_cnt = 0;
        done_idx = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 10) begin
                bif.Start = 1'b1;
                bif.Op    = c_op_mthi;
                bif.A     = 32'h0000_DEAD;
            end
            if (i == 11) bif.Start = 1'b0;
            if (i == 12) check_val("calc_hi_hold", 64'(bif.HI), 64'h4000_0000);
            if (bif.Done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            @(negedge clk);
        end
        check_val("ignore_start_done_count", 64'(done_cnt), 64'd1);
        check_val("ignore_start_done_cycle", 64'(done_idx), 64'd34);
        check_val("ignore_start_hilo", {bif.HI, bif.LO}, 64'd42);

        // Back-to-back: next Start accepted in the Done cycle
        pulse_start(c_op_mult, 32'd5, 32'd5);
        wait_done(cyc);
        check_val("b2b_first_timeout", 64'(cyc < 60), 64'h1);
        check_val("b2b_first_hilo", {bif.HI, bif.LO}, 64'd25);
        bif.Start = 1'b1;
        bif.Op    = c_op_madd;
        bif.A     = 32'hFFFF_FFFD;
        bif.B     = 32'd4;
        @(negedge clk);
        bif.Start = 1'b0;
        check_val("b2b_accept_busy", 64'(bif.Busy), 64'h1);
        check_val("b2b_done_single", 64'(bif.Done), 64'h0);
        wait_done(cyc);
        check_val("b2b_second_timeout", 64'(cyc < 60), 64'h1);
        check_val("b2b_madd_neg_hilo", {bif.HI, bif.LO}, 64'd13);

        // Reset mid-multiply aborts with no Done and no partial write
        pulse_start(c_op_mthi, 32'h1234, 32'h0);
        pulse_start(c_op_mult, 32'd7, 32'd6);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_hi",   64'(bif.HI),   64'h0);
        check_val("abort_lo",   64'(bif.LO),   64'h0);
        check_val("abort_busy", 64'(bif.Busy), 64'h0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (bif.Done) done_cnt++;
            @(negedge clk);
        end
        check_val("abort_no_done", 64'(done_cnt), 64'd0);
        check_val("abort_hilo_after", {bif.HI, bif.LO}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
